// File: rtl/riscv_mem_arbiter.sv
// Shared-memory arbiter for the multicycle core. The instruction-fetch (IF) and
// data-memory (DM) requesters take turns on one single-ported unified memory.
// Only one transaction is in flight at a time, and the memory has a fixed latency.
// The IF requester needs word alignment; the DM requester needs doubleword alignment.
module riscv_mem_arbiter #(
    parameter int MEM_LATENCY   = 2,
    parameter bit DATA_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [63:0] dm_addr_i,
    input  logic [63:0] dm_wdata_i,
    output logic        dm_gnt_o,
    output logic        dm_rvalid_o,
    output logic [63:0] dm_rdata_o,
    output logic        dm_err_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_last_dm;   // the previous winner was DM
    logic            r_sel_dm;    // the current transaction belongs to DM
    logic            r_we;        // the current transaction is a store
    logic            r_err;       // the current transaction is misaligned
    logic            r_lane_hi;   // the IF fetch reads the upper word

    logic            w_issue;
    logic            w_win_dm;
    logic            w_misal;
    logic            w_finish;
    logic [63:0]     w_req_addr;

    logic            r_if_gnt, r_if_rvalid, r_if_err;
    logic [31:0]     r_if_rdata;
    logic            r_dm_gnt, r_dm_rvalid, r_dm_err;
    logic [63:0]     r_dm_rdata;
    logic            r_mem_en, r_mem_we;
    logic [63:0]     r_mem_addr, r_mem_wdata;
    logic            r_busy;

    // Next state, arbitration decision and end-of-transaction detection.
    // A misaligned grant still passes through WAIT for one cycle, so its response
    // lands two cycles after sampling. This also keeps a requester that still
    // holds req during its gnt cycle from being sampled a second time.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_win_dm    = 1'b0;
        w_misal     = 1'b0;
        w_finish    = 1'b0;
        w_req_addr  = if_addr_i;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (if_req_i || dm_req_i) begin
                    w_issue  = 1'b1;
                    w_win_dm = dm_req_i && (!if_req_i || DATA_PRIORITY || !r_last_dm);
                    if (w_win_dm) begin
                        w_req_addr = dm_addr_i;
                        w_misal    = (dm_addr_i[2:0] != 3'b000);
                    end else begin
                        w_req_addr = if_addr_i;
                        w_misal    = (if_addr_i[1:0] != 2'b00);
                    end
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_err) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_mem_en) begin
                    w_state_nxt = ST_WAIT;   // strobe cycle: the countdown starts next cycle
                end else if (r_cnt == '0) begin
                    w_finish    = 1'b1;      // read data is valid in this cycle
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latches the winner's command and runs the latency countdown.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_last_dm <= 1'b1;
            r_sel_dm  <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_lane_hi <= 1'b0;
        end else if (w_issue) begin
            r_cnt     <= CW'(MEM_LATENCY - 1);
            r_last_dm <= w_win_dm;
            r_sel_dm  <= w_win_dm;
            r_we      <= w_win_dm && dm_we_i;
            r_err     <= w_misal;
            r_lane_hi <= if_addr_i[2];
        end else if ((r_state == ST_WAIT) && !r_mem_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Registered grant pulses, memory strobe and response outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_if_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_dm_gnt    <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_dm_err    <= 1'b0;
            r_dm_rdata  <= 64'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 64'd0;
            r_mem_wdata <= 64'd0;
            r_busy      <= 1'b0;
        end else begin
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_if_gnt    <= w_issue && !w_win_dm;
            r_dm_gnt    <= w_issue && w_win_dm;
            r_mem_en    <= w_issue && !w_misal;
            r_mem_we    <= w_issue && !w_misal && w_win_dm && dm_we_i;
            r_mem_addr  <= (w_issue && !w_misal) ? {w_req_addr[63:3], 3'b000} : 64'd0;
            r_mem_wdata <= (w_issue && !w_misal && w_win_dm && dm_we_i) ? dm_wdata_i : 64'd0;
            r_if_rvalid <= w_finish && !r_sel_dm;
            r_if_err    <= w_finish && !r_sel_dm && r_err;
            r_if_rdata  <= (w_finish && !r_sel_dm && !r_err) ?
                           (r_lane_hi ? mem_rdata_i[63:32] : mem_rdata_i[31:0]) : 32'd0;
            r_dm_rvalid <= w_finish && r_sel_dm;
            r_dm_err    <= w_finish && r_sel_dm && r_err;
            r_dm_rdata  <= (w_finish && r_sel_dm && !r_err && !r_we) ? mem_rdata_i : 64'd0;
        end
    end

    assign if_gnt_o    = r_if_gnt;
    assign if_rvalid_o = r_if_rvalid;
    assign if_rdata_o  = r_if_rdata;
    assign if_err_o    = r_if_err;
    assign dm_gnt_o    = r_dm_gnt;
    assign dm_rvalid_o = r_dm_rvalid;
    assign dm_rdata_o  = r_dm_rdata;
    assign dm_err_o    = r_dm_err;
    assign mem_en_o    = r_mem_en;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign busy_o      = r_busy;

endmodule
